ascii_number_parser: RTL and testbench

Receives a byte stream of ASCII characters from the UART receive path and assembles runs of decimal digits into one unsigned 20-bit binary value. Sits between the UART RX byte interface and the command/register logic that consumes numeric operands. Uses a single-digit ASCII decoder and accumulates the value as acc*10 + digit. Emits a one-cycle strobe with the value when a terminator arrives. Flags malformed or oversized numbers.

---
 rtl/ascii_number_parser_pkg.sv | 16 +
 rtl/ascii_digit_decoder.sv | 16 +
 rtl/ascii_number_parser.sv | 101 ++++++++++
 tb/tb_ascii_number_parser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ascii_number_parser_pkg.sv
// Shared constants and state encoding for the ASCII decimal number parser.
package ascii_number_parser_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } parser_state_t;

endpackage

// File: rtl/ascii_digit_decoder.sv
// Classifies one ASCII byte as decimal digit / terminator and extracts the digit value.
module ascii_digit_decoder
  import ascii_number_parser_pkg::*;
(
  input  logic [7:0] data,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_term
);

  assign is_digit = (data >= ASCII_0) && (data <= ASCII_9);
  assign is_term  = (data == ASCII_CR) || (data == ASCII_LF) || (data == ASCII_SP);
  // '0'..'9' are 0x30..0x39, so the low nibble is the digit value; only meaningful when is_digit.
  assign digit    = data[3:0];

endmodule

// File: rtl/ascii_number_parser.sv
// Assembles runs of ASCII decimal digits into an unsigned value, strobed out on a terminator.
//
// state   | meaning
// IDLE    | between numbers; terminators are absorbed
// ACCUM   | collecting digits into acc
// DISCARD | malformed/oversized number seen; drop bytes until a terminator
module ascii_number_parser
  import ascii_number_parser_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int MAX_DIGITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] value_out,
  output logic             value_valid,
  output logic             error,
  output logic             busy,
  output logic [2:0]       digit_count
);

  parser_state_t    state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       digit;
  logic             is_digit;
  logic             is_term;
  logic             room_left;

  ascii_digit_decoder u_decoder (
    .data     (rx_data),
    .digit    (digit),
    .is_digit (is_digit),
    .is_term  (is_term)
  );

  // acc*10 as a shift-add, truncated to WIDTH bits
  assign acc_next  = (acc << 3) + (acc << 1) + WIDTH'(digit);
  assign room_left = digit_count < 3'(MAX_DIGITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      digit_count <= 3'd0;
    end else begin
      value_valid <= 1'b0;
      error       <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (is_digit) begin
              acc         <= WIDTH'(digit);
              digit_count <= 3'd1;
              state       <= ACCUM;
              busy        <= 1'b1;
            end else if (!is_term) begin
              error <= 1'b1;
              state <= DISCARD;
              busy  <= 1'b1;
            end
          end
          ACCUM: begin
            if (is_digit && room_left) begin
              acc         <= acc_next;
              digit_count <= digit_count + 3'd1;
            end else if (is_term) begin
              value_out   <= acc;
              value_valid <= 1'b1;
              digit_count <= 3'd0;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              error <= 1'b1;
              state <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_term) begin
              digit_count <= 3'd0;
              state       <= IDLE;
              busy        <= 1'b0;
            end
          end
          default: begin
            digit_count <= 3'd0;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_number_parser.sv
// Self-checking bench: directed strings plus random byte streams against a token-level model.
module tb_ascii_number_parser;

  localparam int WIDTH      = 20;
  localparam int MAX_DIGITS = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] value_out;
  logic             value_valid;
  logic             error;
  logic             busy;
  logic [2:0]       digit_count;

  int checks   = 0;
  int failures = 0;

  // model: the current token as a list of digit values, plus a "bad token" flag
  int   tok[$];
  bit   bad;
  int   exp_value;
  bit   exp_vv;
  bit   exp_err;

  ascii_number_parser #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .value_out   (value_out),
    .value_valid (value_valid),
    .error       (error),
    .busy        (busy),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  function automatic bit is_dig(input logic [7:0] b);
    return (b >= 8'd48) && (b <= 8'd57);
  endfunction

  function automatic bit is_trm(input logic [7:0] b);
    return (b == 8'd13) || (b == 8'd10) || (b == 8'd32);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tok.delete();
    bad       = 1'b0;
    exp_value = 0;
    exp_vv    = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic model_byte(input logic v, input logic [7:0] b);
    int acc;
    exp_vv  = 1'b0;
    exp_err = 1'b0;
    if (v) begin
      if (is_trm(b)) begin
        if (!bad && tok.size() > 0) begin
          acc = 0;
          foreach (tok[i]) acc = acc * 10 + tok[i];
          exp_value = acc;
          exp_vv    = 1'b1;
        end
        tok.delete();
        bad = 1'b0;
      end else if (!bad) begin
        if (is_dig(b) && tok.size() < MAX_DIGITS) tok.push_back(int'(b) - 48);
        else begin
          exp_err = 1'b1;
          bad     = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".value_out"},   32'(value_out),   32'(exp_value));
    chk({where, ".value_valid"}, 32'(value_valid), 32'(exp_vv));
    chk({where, ".error"},       32'(error),       32'(exp_err));
    chk({where, ".busy"},        32'(busy),        32'(bad || tok.size() > 0));
    chk({where, ".digit_count"}, 32'(digit_count), 32'(tok.size()));
  endtask

  task automatic step(input logic v, input logic [7:0] b, input string where);
    rx_valid = v;
    rx_data  = b;
    @(posedge clk);
    #1;
    model_byte(v, b);
    check_all(where);
  endtask

  task automatic send_str(input string s, input int gap, input string where);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i], where);
      for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), where);
    end
  endtask

  task automatic idle_cycle(input string where);
    step(1'b0, 8'($urandom), where);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 99);
    if (r < 62) return 8'(48 + $urandom_range(0, 9));
    if (r < 84) begin
      case ($urandom_range(0, 2))
        0:       return 8'd13;
        1:       return 8'd10;
        default: return 8'd32;
      endcase
    end
    do b = 8'($urandom); while (is_dig(b) || is_trm(b));
    return b;
  endfunction

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // "123\r" at full rate
    send_str("123", 0, "s123");
    step(1'b1, 8'd13, "s123_cr");
    chk("s123_val", 32'(value_out), 32'd123);
    idle_cycle("s123_after");

    // max-width number, then an unrelated one
    send_str("999999 ", 0, "s999999");
    chk("s999999_val", 32'(value_out), 32'h0F423F);
    send_str("42", 0, "s42");
    step(1'b1, 8'd10, "s42_lf");

    // too many digits, then recovery
    send_str("1234567", 0, "s7dig");
    step(1'b1, 8'd13, "s7dig_cr");
    send_str("5", 0, "s5");
    step(1'b1, 8'd13, "s5_cr");
    chk("s5_val", 32'(value_out), 32'd5);

    // leading zeros count as digits
    send_str("000001 ", 0, "s000001");
    send_str("0000001 ", 0, "s0000001");

    // malformed, then bare line endings
    send_str("12a3", 0, "s12a3");
    step(1'b1, 8'd13, "s12a3_cr");
    step(1'b1, 8'd13, "crlf0");
    step(1'b1, 8'd10, "crlf1");
    step(1'b1, 8'd13, "crlf2");
    step(1'b1, 8'd10, "crlf3");
    send_str("x ", 0, "sx");

    // gaps with garbage on rx_data while rx_valid is low
    send_str("807", 3, "s807");
    step(1'b1, 8'd10, "s807_lf");
    chk("s807_val", 32'(value_out), 32'd807);

    // asynchronous reset mid-number
    send_str("4", 0, "s45");
    rx_valid = 1'b1;
    rx_data  = 8'd53;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    reset = 1'b0;
    send_str("6", 0, "s6");
    step(1'b1, 8'd13, "s6_cr");
    chk("s6_val", 32'(value_out), 32'd6);

    // random streams
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle("rand_gap");
      else step(1'b1, rand_byte(), "rand");
    end
    // long digit runs to exercise the overflow path at random values
    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) step(1'b1, 8'(48 + $urandom_range(0, 9)), "rand_run");
      step(1'b1, 8'd32, "rand_run_sp");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
